// File: rtl/multiplier_seq_led_board_if.sv
// Handshake and data bundle for the sequential multiplier board.
// The master side launches operations and picks the displayed half;
// the slave side (the multiplier) reports completion and the held product.
interface multiplier_seq_led_board_if #(
  parameter int WIDTH = 16
);
  logic               start;
  logic [WIDTH-1:0]   a;
  logic [WIDTH-1:0]   b;
  logic               sel_hi;
  logic               done;
  logic               busy;
  logic [2*WIDTH-1:0] product;

  modport master (
    output start, a, b, sel_hi,
    input  done, busy, product
  );

  modport slave (
    input  start, a, b, sel_hi,
    output done, busy, product
  );
endinterface

// File: rtl/multiplier_seq_led_board.sv
// Sequential shift-add unsigned multiplier with a 4-digit multiplexed
// 7-segment readout of either half of the last completed product.
// start is an active-low button.  A held button launches only once and must
// be released before it can launch again.
module multiplier_seq_led_board #(
  parameter int WIDTH    = 16,
  parameter int SCAN_DIV = 50000
) (
  input  logic                        clk,
  input  logic                        rst,
  multiplier_seq_led_board_if.slave   bus,
  output logic                        led1,
  output logic                        led2,
  output logic                        led3,
  output logic                        led4,
  output logic [6:0]                  out
);

  localparam int CNT_W  = $clog2(WIDTH + 1);
  localparam int SCAN_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CNT_W-1:0]  CNT_INIT  = CNT_W'(WIDTH);
  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(1);
  localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(SCAN_DIV - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t             state;
  logic [WIDTH-1:0]   mcand;
  logic [WIDTH-1:0]   mplier;
  logic [2*WIDTH-1:0] acc;
  logic [CNT_W-1:0]   count;
  logic               armed;
  logic               done_r;
  logic               busy_r;
  logic [2*WIDTH-1:0] product_r;
  logic [WIDTH:0]     sum;

  logic [SCAN_W-1:0]  scan_cnt;
  logic [1:0]         digit_sel;
  logic [15:0]        dw;
  logic [3:0]         nibble;
  logic [3:0]         led_r;

  assign bus.done    = done_r;
  assign bus.busy    = busy_r;
  assign bus.product = product_r;
  assign led1 = led_r[0];
  assign led2 = led_r[1];
  assign led3 = led_r[2];
  assign led4 = led_r[3];

  // Upper accumulator half plus multiplicand, keeping the carry bit
  always_comb begin
    sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, mcand};
  end

  // Control FSM and shift-add datapath; product and flags are registered
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= S_IDLE;
      mcand     <= '0;
      mplier    <= '0;
      acc       <= '0;
      count     <= '0;
      armed     <= 1'b1;
      done_r    <= 1'b0;
      busy_r    <= 1'b0;
      product_r <= '0;
    end else begin
      done_r <= 1'b0;
      if (bus.start) begin
        armed <= 1'b1;
      end
      case (state)
        S_IDLE: begin
          if (!bus.start && armed) begin
            mcand  <= bus.a;
            mplier <= bus.b;
            acc    <= '0;
            count  <= CNT_INIT;
            armed  <= 1'b0;
            busy_r <= 1'b1;
            state  <= S_RUN;
          end
        end
        S_RUN: begin
          if (mplier[0]) begin
            acc <= {sum, acc[WIDTH-1:1]};
          end else begin
            acc <= {1'b0, acc[2*WIDTH-1:1]};
          end
          mplier <= mplier >> 1;
          count  <= count - 1'b1;
          if (count == CNT_LAST) begin
            state <= S_DONE;
          end
        end
        S_DONE: begin
          product_r <= acc;
          done_r    <= 1'b1;
          busy_r    <= 1'b0;
          state     <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Digit scan timer: each digit stays selected for SCAN_DIV cycles
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      scan_cnt  <= '0;
      digit_sel <= 2'd0;
    end else if (scan_cnt == SCAN_LAST) begin
      scan_cnt  <= '0;
      digit_sel <= digit_sel + 2'd1;
    end else begin
      scan_cnt  <= scan_cnt + 1'b1;
    end
  end

  // Pick the displayed half and the nibble for the selected digit
  always_comb begin
    dw     = bus.sel_hi ? product_r[31:16] : product_r[15:0];
    nibble = dw[{digit_sel, 2'b00} +: 4];
  end

  // Active-low {g,f,e,d,c,b,a} hex decode
  function automatic logic [6:0] seg7(input logic [3:0] n);
    case (n)
      4'h0: seg7 = 7'b1000000;
      4'h1: seg7 = 7'b1111001;
      4'h2: seg7 = 7'b0100100;
      4'h3: seg7 = 7'b0110000;
      4'h4: seg7 = 7'b0011001;
      4'h5: seg7 = 7'b0010010;
      4'h6: seg7 = 7'b0000010;
      4'h7: seg7 = 7'b1111000;
      4'h8: seg7 = 7'b0000000;
      4'h9: seg7 = 7'b0010000;
      4'hA: seg7 = 7'b0001000;
      4'hB: seg7 = 7'b0000011;
      4'hC: seg7 = 7'b1000110;
      4'hD: seg7 = 7'b0100001;
      4'hE: seg7 = 7'b0000110;
      default: seg7 = 7'b0001110;
    endcase
  endfunction

  // Registered digit enables and segments, so the one-hot never glitches
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      led_r <= 4'b0000;
      out   <= 7'b1111111;
    end else begin
      led_r <= 4'b0001 << digit_sel;
      out   <= seg7(nibble);
    end
  end

endmodule

// File: tb/tb_multiplier_seq_led_board.sv
// Directed bench for multiplier_seq_led_board (SCAN_DIV shortened to 4).
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_multiplier_seq_led_board;

  logic       clk = 1'b0;
  logic       rst;
  logic       led1, led2, led3, led4;
  logic [6:0] out;
  logic [3:0] leds;
  int         vectors = 0;
  int         miscompares = 0;

  multiplier_seq_led_board_if #(.WIDTH(16)) bus ();

  multiplier_seq_led_board #(.WIDTH(16), .SCAN_DIV(4)) dut (
    .clk  (clk),
    .rst  (rst),
    .bus  (bus),
    .led1 (led1),
    .led2 (led2),
    .led3 (led3),
    .led4 (led4),
    .out  (out)
  );

  assign leds = {led4, led3, led2, led1};

  always #5 clk = ~clk;

  task automatic check_output(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // One launch with a single-cycle start pulse; checks latency, busy span, result
  task automatic apply_stimulus(input logic [15:0] ta, input logic [15:0] tbv,
                                input logic [31:0] exp, input string tag);
    int lat;
    int busy_cycles;
    @(negedge clk);
    bus.a = ta;
    bus.b = tbv;
    bus.start = 1'b0;
    @(negedge clk);
    bus.start = 1'b1;
    lat = -1;
    busy_cycles = 0;
    for (int i = 0; i < 40; i++) begin
      if (bus.done) begin
        lat = i;
        break;
      end
      if (bus.busy) busy_cycles++;
      @(negedge clk);
    end
    check_output({tag, "_latency"}, lat, 17);
    check_output({tag, "_busy_cycles"}, busy_cycles, 17);
    check_output({tag, "_product"}, bus.product, exp);
    check_output({tag, "_busy_at_done"}, {31'd0, bus.busy}, 32'd0);
    @(negedge clk);
    check_output({tag, "_done_single"}, {31'd0, bus.done}, 32'd0);
  endtask

  // Align on the led1 rising point, then walk all four digits and the wrap
  task automatic check_scan(input logic [6:0] s0, input logic [6:0] s1,
                            input logic [6:0] s2, input logic [6:0] s3,
                            input string tag);
    logic [6:0] segs [4];
    logic [3:0] prev;
    logic       found;
    segs[0] = s0;
    segs[1] = s1;
    segs[2] = s2;
    segs[3] = s3;
    found = 1'b0;
    prev = leds;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (leds == 4'b0001 && prev != 4'b0001) begin
        found = 1'b1;
        break;
      end
      prev = leds;
    end
    check_output({tag, "_align"}, {31'd0, found}, 32'd1);
    for (int k = 0; k < 4; k++) begin
      for (int j = 0; j < 4; j++) begin
        if (k != 0 || j != 0) @(negedge clk);
        check_output($sformatf("%s_led_d%0d_c%0d", tag, k, j), {28'd0, leds},
                     {28'd0, 4'(4'b0001 << k)});
        check_output($sformatf("%s_seg_d%0d_c%0d", tag, k, j), {25'd0, out},
                     {25'd0, segs[k]});
      end
    end
    @(negedge clk);
    check_output({tag, "_wrap"}, {28'd0, leds}, 32'd1);
  endtask

  initial begin
    int pulses;
    rst = 1'b1;
    bus.start = 1'b1;
    bus.a = '0;
    bus.b = '0;
    bus.sel_hi = 1'b0;
    #2 rst = 1'b0;
    #1;
    check_output("reset_done", {31'd0, bus.done}, 32'd0);
    check_output("reset_busy", {31'd0, bus.busy}, 32'd0);
    check_output("reset_product", bus.product, 32'd0);
    check_output("reset_leds", {28'd0, leds}, 32'd0);
    check_output("reset_out", {25'd0, out}, 32'h7F);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    $display("[TB] basic multiply");
    apply_stimulus(16'h2A5E, 16'h0003, 32'h00007F1A, "t1");

    $display("[TB] full-scale operands, high half displayed");
    apply_stimulus(16'hFFFF, 16'hFFFF, 32'hFFFE0001, "t2");
    bus.sel_hi = 1'b1;
    check_scan(7'b0000110, 7'b0001110, 7'b0001110, 7'b0001110, "t2_scan");

    $display("[TB] zero operands");
    apply_stimulus(16'h0000, 16'h1234, 32'h0, "t3a");
    apply_stimulus(16'h1234, 16'h0000, 32'h0, "t3b");
    bus.sel_hi = 1'b0;
    check_scan(7'b1000000, 7'b1000000, 7'b1000000, 7'b1000000, "t3_scan");

    $display("[TB] low half scan of 0x1234");
    apply_stimulus(16'h1234, 16'h0001, 32'h00001234, "t6");
    check_scan(7'b0011001, 7'b0110000, 7'b0100100, 7'b1111001, "t6_scan");

    $display("[TB] held start and mid-run operand changes");
    @(negedge clk);
    bus.a = 16'h0100;
    bus.b = 16'h0101;
    bus.start = 1'b0;
    pulses = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (i == 5) begin
        bus.a = 16'hFFFF;
        bus.b = 16'hFFFF;
      end
      if (bus.done) pulses++;
    end
    bus.start = 1'b1;
    check_output("t4_held_pulses", pulses, 1);
    check_output("t4_held_product", bus.product, 32'h00010100);
    apply_stimulus(16'h1234, 16'h0010, 32'h00012340, "t4_relaunch");

    $display("[TB] reset during run");
    @(negedge clk);
    bus.a = 16'hFFFF;
    bus.b = 16'hFFFF;
    bus.start = 1'b0;
    @(negedge clk);
    bus.start = 1'b1;
    repeat (7) @(negedge clk);
    check_output("t5_busy_before", {31'd0, bus.busy}, 32'd1);
    rst = 1'b0;
    #1;
    check_output("t5_done", {31'd0, bus.done}, 32'd0);
    check_output("t5_busy", {31'd0, bus.busy}, 32'd0);
    check_output("t5_product", bus.product, 32'd0);
    check_output("t5_leds", {28'd0, leds}, 32'd0);
    check_output("t5_out", {25'd0, out}, 32'h7F);
    @(negedge clk);
    rst = 1'b1;
    pulses = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.done) pulses++;
    end
    check_output("t5_no_done", pulses, 0);
    check_output("t5_idle_busy", {31'd0, bus.busy}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
